misc_st_responder: RTL
======================

MISC_ST_RESPONDER -- requirements
Module: misc_st_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of write and read data.
REQ-002 Parameter ADDR_WIDTH, default 8: width of request address.
REQ-003 Parameter NUM_REGS, default 16: register-file entries at addresses 0..NUM_REGS-1.
REQ-004 Parameter RSP_DEPTH, default 2: response FIFO entries.
REQ-005 Ports clk (input, 1) and reset (input, 1): one clock, reset synchronous and active-high; all state samples on rising clk.
REQ-006 Ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-007 Port req_we (input, 1): request type, 1 write, 0 read.
REQ-008 Ports req_addr (input, ADDR_WIDTH) and req_wdata (input, DATA_WIDTH): request target address and write data.
REQ-009 Ports rsp_valid (output, 1) and rsp_ready (input, 1): response handshake.
REQ-010 Ports rsp_rdata (output, DATA_WIDTH) and rsp_err (output, 1): read data (0 for writes) and error flag.

Function
REQ-011 Request accepted on a cycle with req_valid and req_ready both 1; response beat consumed on a cycle with rsp_valid and rsp_ready both 1.
REQ-012 req_ready = 1 exactly when FIFO occupancy < RSP_DEPTH; req_ready has no combinational dependence on rsp_ready or req_* inputs.
REQ-013 Each accepted request produces exactly one response, responses strictly in acceptance order.
REQ-014 Response enters FIFO on the edge that accepts the request; rsp_valid rises the cycle after acceptance (latency 1) when FIFO was empty.
REQ-015 Accepted write, addr < NUM_REGS: register updated on the accepting edge; response rdata=0, err=0.
REQ-016 Accepted read, addr < NUM_REGS: response rdata = register value before any write in the same cycle; err=0.
REQ-017 Address ADDR_WIDTH'(all ones) is the read-only status register: read returns {zero-extend, err_count[15:0]}, err=0; write is ignored, err=1.
REQ-018 Any other addr >= NUM_REGS: register file unchanged, response rdata=0, err=1.
REQ-019 err_count: 16-bit, increments on each accepted request whose response has err=1, saturates at 16'hFFFF.
REQ-020 Response fields stay stable while rsp_valid=1 and rsp_ready=0.
REQ-021 Simultaneous push and pop: occupancy unchanged; FIFO full with pop that cycle still keeps req_ready=0 (no fall-through).
REQ-022 FIFO read/write pointers wrap modulo RSP_DEPTH; occupancy counter width $clog2(RSP_DEPTH+1).

Reset
REQ-023 While reset=1: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FIFO empty, err_count=0, all registers 0.
REQ-024 Reset asserted mid-operation discards all queued responses and in-flight requests; no response for them is ever issued.
REQ-025 First cycle after reset deasserts: req_ready=1.

Structure
REQ-026 Shared package misc_st_pkg holds response struct type (rdata, err), status-address constant, err_count width constant.
REQ-027 Response queue is sub-module misc_st_rsp_fifo (parameterized width/depth, push/pop/full/empty/count); register file and decode stay in top.

Verification
REQ-028 Write 0xDEADBEEF to addr 3, then read addr 3, rsp_ready=1 -> responses {0,err0} then {0xDEADBEEF,err0}, each 1 cycle after acceptance.
REQ-029 rsp_ready=0, three back-to-back reads -> first two accepted, req_ready=0 on third; after rsp_ready=1, third accepted, three in-order responses.
REQ-030 Read addr 16, write addr 0x20, read addr 0xFF -> err=1, err=1, then rdata=2 err=0; write 0xFF -> err=1, err_count=3.
REQ-031 Write addr 5 and read addr 5 on consecutive accepting cycles under continuous rsp_ready=1 -> read returns written value; no bubbles, req_ready held 1.
REQ-032 Assert reset with two queued responses -> rsp_valid=0 next cycle, reads of addr 3 and 0xFF return 0 afterwards.
REQ-033 Drive 65537 erroneous requests -> err_count reads 0xFFFF, no wrap.

Source files
------------

// File: rtl/misc_st_pkg.sv
// Types and constants shared by the responder top and its response queue.
package misc_st_pkg;

    localparam int ERR_CNT_W  = 16;
    localparam int RSP_DATA_W = 32;

    // All-ones pattern; the top slices it to its own address width.
    localparam logic [63:0] STATUS_ADDR = '1;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/misc_st_rsp_fifo.sv
// Response queue: circular buffer with an occupancy counter and no fall-through.
module misc_st_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/misc_st_responder.sv
// Valid/ready register-file responder: decodes requests, queues one response
// per accepted request and tracks a saturating error counter at the status address.
module misc_st_responder
    import misc_st_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = STATUS_ADDR[ADDR_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [ERR_CNT_W-1:0]  err_count_reg;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    rsp_t                  rsp_next;
    rsp_t                  rsp_head;
    logic                  accept;
    logic                  pop;
    logic                  is_status;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // Outputs are forced idle while reset is held, even before the queue clears.
    assign req_ready = (fifo_count < CNT_W'(RSP_DEPTH)) & ~reset;
    assign rsp_valid = ~fifo_empty & ~reset;
    assign rsp_rdata = rsp_valid ? DATA_WIDTH'(rsp_head.rdata) : '0;
    assign rsp_err   = rsp_valid & rsp_head.err;

    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign is_status = (req_addr == STAT_ADDR);
    assign in_range  = ~is_status && (int'(req_addr) < NUM_REGS);
    assign idx       = req_addr[IDX_W-1:0];

    always_comb begin
        rsp_next = '0;
        if (is_status) begin
            if (req_we) begin
                rsp_next.err = 1'b1;
            end else begin
                rsp_next.rdata = RSP_DATA_W'(err_count_reg);
            end
        end else if (in_range) begin
            if (!req_we) begin
                rsp_next.rdata = RSP_DATA_W'(regs_reg[idx]);
            end
        end else begin
            rsp_next.err = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (accept && req_we && in_range && idx == IDX_W'(gi)) begin
                    regs_reg[gi] <= req_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= '0;
        end else if (accept && rsp_next.err) begin
            err_count_reg <= sat_inc(err_count_reg);
        end
    end

    // full is redundant with the occupancy test above but keeps the push guard local.
    misc_st_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (accept & ~fifo_full),
        .wdata (rsp_next),
        .pop   (pop),
        .rdata (rsp_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
